// File: rtl/text_mem_pkg.sv
// Shared types and field layout for the text-mode memory arbiter.
package text_mem_pkg;

    // Source of the access issued in the previous cycle.
    typedef enum logic [1:0] {
        SRC_NONE   = 2'd0,
        SRC_DISP   = 2'd1,
        SRC_BUS_RD = 2'd2,
        SRC_BUS_WR = 2'd3
    } mem_src_e;

    // Text RAM word width.
    localparam int unsigned TextDataWidth = 16;

    // Cell layout inside a text RAM word.
    localparam int unsigned CharLsb   = 0;
    localparam int unsigned CharWidth = 8;
    localparam int unsigned FgLsb     = 8;
    localparam int unsigned FgWidth   = 4;
    localparam int unsigned BgLsb     = 12;
    localparam int unsigned BgWidth   = 4;

endpackage

// File: rtl/text_mem_arbiter.sv
// Text RAM arbiter: the display refresh owns every active pixel strobe,
// the host bus gets all remaining cycles. One access per cycle, read
// data returns one cycle after issue and is routed by a registered tag.
module text_mem_arbiter
    import text_mem_pkg::*;
#(
    parameter int unsigned TextMemAddrWidth = 14,
    parameter int unsigned StallCntWidth    = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,

    input  logic                        display_en_i,
    input  logic                        disp_active_i,
    input  logic [TextMemAddrWidth-1:0] disp_addr_i,
    output logic [CharWidth-1:0]        disp_char_o,
    output logic [FgWidth-1:0]          disp_fg_o,
    output logic [BgWidth-1:0]          disp_bg_o,

    input  logic                        bus_req_i,
    input  logic                        bus_we_i,
    input  logic [1:0]                  bus_be_i,
    input  logic [TextMemAddrWidth-1:0] bus_addr_i,
    input  logic [TextDataWidth-1:0]    bus_wdata_i,
    output logic                        bus_gnt_o,
    output logic                        bus_rvalid_o,
    output logic [TextDataWidth-1:0]    bus_rdata_o,

    output logic                        mem_req_o,
    output logic                        mem_we_o,
    output logic [1:0]                  mem_be_o,
    output logic [TextMemAddrWidth-1:0] mem_addr_o,
    output logic [TextDataWidth-1:0]    mem_wdata_o,
    input  logic [TextDataWidth-1:0]    mem_rdata_i,

    input  logic                        stall_clr_i,
    output logic [StallCntWidth-1:0]    stall_cnt_o
);

    mem_src_e                src_q, src_d;
    logic [CharWidth-1:0]    char_q;
    logic [FgWidth-1:0]      fg_q;
    logic [BgWidth-1:0]      bg_q;
    logic [StallCntWidth-1:0] stall_q, stall_d;
    logic                    disp_slot;

    assign disp_slot = display_en_i && disp_active_i;

    // Arbitration: display slot first, then bus; nothing is issued in reset.
    always_comb begin
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_be_o    = '0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        bus_gnt_o   = 1'b0;
        src_d       = SRC_NONE;
        if (rst_ni) begin
            if (disp_slot) begin
                mem_req_o  = 1'b1;
                mem_be_o   = '1;
                mem_addr_o = disp_addr_i;
                src_d      = SRC_DISP;
            end else if (bus_req_i) begin
                mem_req_o   = 1'b1;
                bus_gnt_o   = 1'b1;
                mem_we_o    = bus_we_i;
                mem_be_o    = bus_we_i ? bus_be_i : 2'b11;
                mem_addr_o  = bus_addr_i;
                mem_wdata_o = bus_wdata_i;
                src_d       = bus_we_i ? SRC_BUS_WR : SRC_BUS_RD;
            end
        end
    end

    // Source tag: remembers who owns the read data arriving next cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            src_q <= SRC_NONE;
        end else begin
            src_q <= src_d;
        end
    end

    // Display data registers: capture the returning cell on a display tag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            char_q <= '0;
            fg_q   <= '0;
            bg_q   <= '0;
        end else if (src_q == SRC_DISP) begin
            char_q <= mem_rdata_i[CharLsb +: CharWidth];
            fg_q   <= mem_rdata_i[FgLsb +: FgWidth];
            bg_q   <= mem_rdata_i[BgLsb +: BgWidth];
        end
    end

    assign disp_char_o = char_q;
    assign disp_fg_o   = fg_q;
    assign disp_bg_o   = bg_q;

    // Bus response: writes complete with zero data, reads pass RAM data through.
    always_comb begin
        bus_rvalid_o = (src_q == SRC_BUS_RD) || (src_q == SRC_BUS_WR);
        bus_rdata_o  = (src_q == SRC_BUS_RD) ? mem_rdata_i : '0;
    end

    // Stall counter next state: clear wins, otherwise saturating increment.
    always_comb begin
        stall_d = stall_q;
        if (stall_clr_i) begin
            stall_d = '0;
        end else if (bus_req_i && !bus_gnt_o && (stall_q != '1)) begin
            stall_d = stall_q + {{(StallCntWidth-1){1'b0}}, 1'b1};
        end
    end

    // Stall counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt_o = stall_q;

endmodule

// File: tb/tb_text_mem_arbiter.sv
// Self-checking bench for text_mem_arbiter with a one-cycle-latency RAM model
// and a scoreboard for bus responses.
module tb_text_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        display_en_i, disp_active_i;
    logic [13:0] disp_addr_i;
    logic [7:0]  disp_char_o;
    logic [3:0]  disp_fg_o, disp_bg_o;
    logic        bus_req_i, bus_we_i;
    logic [1:0]  bus_be_i;
    logic [13:0] bus_addr_i;
    logic [15:0] bus_wdata_i;
    logic        bus_gnt_o, bus_rvalid_o;
    logic [15:0] bus_rdata_o;
    logic        mem_req_o, mem_we_o;
    logic [1:0]  mem_be_o;
    logic [13:0] mem_addr_o;
    logic [15:0] mem_wdata_o;
    logic [15:0] mem_rdata;
    logic        stall_clr_i;
    logic [15:0] stall_cnt_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    text_mem_arbiter #(
        .TextMemAddrWidth(14),
        .StallCntWidth   (16)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .display_en_i (display_en_i),
        .disp_active_i(disp_active_i),
        .disp_addr_i  (disp_addr_i),
        .disp_char_o  (disp_char_o),
        .disp_fg_o    (disp_fg_o),
        .disp_bg_o    (disp_bg_o),
        .bus_req_i    (bus_req_i),
        .bus_we_i     (bus_we_i),
        .bus_be_i     (bus_be_i),
        .bus_addr_i   (bus_addr_i),
        .bus_wdata_i  (bus_wdata_i),
        .bus_gnt_o    (bus_gnt_o),
        .bus_rvalid_o (bus_rvalid_o),
        .bus_rdata_o  (bus_rdata_o),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_be_o     (mem_be_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_rdata_i  (mem_rdata),
        .stall_clr_i  (stall_clr_i),
        .stall_cnt_o  (stall_cnt_o)
    );

    // RAM model: byte-enabled writes, registered read data, plus a preload port.
    logic [15:0] mem [0:16383];
    logic        pre_we = 1'b0;
    logic [13:0] pre_addr = '0;
    logic [15:0] pre_data = '0;

    always @(posedge clk) begin
        if (pre_we) begin
            mem[pre_addr] <= pre_data;
        end else if (mem_req_o) begin
            if (mem_we_o) begin
                if (mem_be_o[0]) mem[mem_addr_o][7:0]  <= mem_wdata_o[7:0];
                if (mem_be_o[1]) mem[mem_addr_o][15:8] <= mem_wdata_o[15:8];
            end else begin
                mem_rdata <= mem[mem_addr_o];
            end
        end
    end

    logic [15:0] sbq [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: each grant must be answered in the following cycle.
    task automatic monitor();
        logic [15:0] e;
        if (!rst_ni) begin
            sbq.delete();
            chk("rvalid_in_reset", 32'(bus_rvalid_o), 32'(1'b0));
        end else begin
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("sb_rvalid", 32'(bus_rvalid_o), 32'(1'b1));
                chk("sb_rdata", 32'(bus_rdata_o), 32'(e));
            end else begin
                chk("sb_no_rvalid", 32'(bus_rvalid_o), 32'(1'b0));
            end
            if (bus_gnt_o) sbq.push_back(bus_we_i ? 16'h0000 : mem[bus_addr_i]);
        end
    endtask

    task automatic sample();
        @(negedge clk);
        monitor();
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic poke(input logic [13:0] a, input logic [15:0] d);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        adv();
        pre_we = 1'b0;
    endtask

    task automatic idle_inputs();
        display_en_i = 1'b0; disp_active_i = 1'b0; bus_req_i = 1'b0;
        bus_we_i = 1'b0; bus_be_i = 2'b00; stall_clr_i = 1'b0;
    endtask

    typedef struct {
        logic       en, act, req, we;
        logic [1:0] be;
        logic       exp_req, exp_gnt, exp_we, exp_bus;
        logic [1:0] exp_be;
    } vec_t;

    vec_t        vecs [7];
    logic [15:0] cells [8];

    initial begin
        int n_acc, n_rv;
        logic any_gnt;
        logic [15:0] w;

        vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00};
        vecs[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 2'b01, 1'b1, 1'b1, 1'b0, 1'b1, 2'b11};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 1'b1, 2'b10, 1'b1, 1'b1, 1'b1, 1'b1, 2'b10};
        vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00};
        vecs[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 2'b11};
        vecs[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00};

        // Reset with requests pending: nothing may be issued or granted.
        rst_ni = 1'b0;
        idle_inputs();
        disp_addr_i = '0; bus_addr_i = '0; bus_wdata_i = '0;
        poke(14'h0010, 16'h5A41);
        poke(14'h0020, 16'hC3B7);
        for (int i = 0; i < 8; i++) poke(14'h0100 + 14'(i), 16'h6000 + 16'(i));
        poke(14'h0100, 16'h1234);
        for (int i = 0; i < 8; i++) begin
            cells[i] = {4'(i), 4'(~i), 8'h40 + 8'(i)};
            poke(14'h0030 + 14'(i), cells[i]);
            poke(14'h0200 + 14'(i), 16'hA500 + 16'(i));
        end
        display_en_i = 1'b1; disp_active_i = 1'b1; bus_req_i = 1'b1;
        sample();
        chk("reset_mem_req", 32'(mem_req_o), 32'(1'b0));
        chk("reset_gnt", 32'(bus_gnt_o), 32'(1'b0));
        chk("reset_disp", 32'({disp_bg_o, disp_fg_o, disp_char_o}), 32'(16'h0000));
        chk("reset_stall", 32'(stall_cnt_o), 32'(16'h0000));
        adv();
        rst_ni = 1'b1;
        idle_inputs();

        // Arbitration table, one row per cycle, back to back.
        for (int i = 0; i < 7; i++) begin
            display_en_i = vecs[i].en; disp_active_i = vecs[i].act;
            bus_req_i = vecs[i].req; bus_we_i = vecs[i].we; bus_be_i = vecs[i].be;
            disp_addr_i = 14'h0020;
            bus_addr_i  = 14'h0100 + 14'(i);
            bus_wdata_i = 16'hBE00 + 16'(i);
            sample();
            chk($sformatf("vec%0d_req", i), 32'(mem_req_o), 32'(vecs[i].exp_req));
            chk($sformatf("vec%0d_gnt", i), 32'(bus_gnt_o), 32'(vecs[i].exp_gnt));
            if (vecs[i].exp_req) begin
                chk($sformatf("vec%0d_we", i), 32'(mem_we_o), 32'(vecs[i].exp_we));
                chk($sformatf("vec%0d_addr", i), 32'(mem_addr_o),
                    32'(vecs[i].exp_bus ? bus_addr_i : disp_addr_i));
                if (vecs[i].exp_bus) chk($sformatf("vec%0d_be", i), 32'(mem_be_o), 32'(vecs[i].exp_be));
                if (vecs[i].exp_we) chk($sformatf("vec%0d_wdata", i), 32'(mem_wdata_o), 32'(bus_wdata_i));
            end
            adv();
        end
        idle_inputs();

        // Display slot at 0x10: data visible two cycles later, held one cycle after.
        display_en_i = 1'b1; disp_active_i = 1'b1; disp_addr_i = 14'h0010;
        sample();
        chk("disp_slot_addr", 32'(mem_addr_o), 32'(14'h0010));
        chk("disp_slot_req", 32'(mem_req_o), 32'(1'b1));
        adv();
        idle_inputs();
        sample();
        chk("disp_hold_char", 32'(disp_char_o), 32'(8'hB7));
        adv();
        sample();
        chk("disp_char", 32'(disp_char_o), 32'(8'h41));
        chk("disp_fg", 32'(disp_fg_o), 32'(4'hA));
        chk("disp_bg", 32'(disp_bg_o), 32'(4'h5));
        adv();

        // Bus read in an idle cycle.
        bus_req_i = 1'b1; bus_we_i = 1'b0; bus_addr_i = 14'h0100; bus_be_i = 2'b00;
        sample();
        chk("rd_gnt", 32'(bus_gnt_o), 32'(1'b1));
        chk("rd_be", 32'(mem_be_o), 32'(2'b11));
        adv();
        idle_inputs();
        sample();
        chk("rd_rvalid", 32'(bus_rvalid_o), 32'(1'b1));
        chk("rd_rdata", 32'(bus_rdata_o), 32'(16'h1234));
        adv();

        // Bus write stalled by a slot, then granted in the next free cycle.
        stall_clr_i = 1'b1;
        sample();
        adv();
        stall_clr_i = 1'b0;
        sample();
        chk("stall_cleared", 32'(stall_cnt_o), 32'(16'h0000));
        adv();
        display_en_i = 1'b1; disp_active_i = 1'b1; disp_addr_i = 14'h0011;
        bus_req_i = 1'b1; bus_we_i = 1'b1; bus_be_i = 2'b01;
        bus_addr_i = 14'h0002; bus_wdata_i = 16'h00FF;
        sample();
        chk("wr_blocked_gnt", 32'(bus_gnt_o), 32'(1'b0));
        chk("wr_blocked_we", 32'(mem_we_o), 32'(1'b0));
        adv();
        display_en_i = 1'b0; disp_active_i = 1'b0;
        sample();
        chk("wr_stall_cnt", 32'(stall_cnt_o), 32'(16'h0001));
        chk("wr_gnt", 32'(bus_gnt_o), 32'(1'b1));
        chk("wr_we", 32'(mem_we_o), 32'(1'b1));
        chk("wr_be", 32'(mem_be_o), 32'(2'b01));
        chk("wr_addr", 32'(mem_addr_o), 32'(14'h0002));
        adv();
        idle_inputs();
        sample();
        chk("wr_rvalid", 32'(bus_rvalid_o), 32'(1'b1));
        chk("wr_rdata", 32'(bus_rdata_o), 32'(16'h0000));
        chk("wr_stall_kept", 32'(stall_cnt_o), 32'(16'h0001));
        adv();

        // Alternating display/bus cycles.
        n_acc = 0; n_rv = 0;
        for (int i = 0; i < 8; i++) begin
            idle_inputs();
            if (i % 2 == 0) begin
                display_en_i = 1'b1; disp_active_i = 1'b1; disp_addr_i = 14'h0030 + 14'(i);
            end else begin
                bus_req_i = 1'b1; bus_addr_i = 14'h0200 + 14'(i);
            end
            sample();
            if (mem_req_o) n_acc++;
            if (bus_rvalid_o) n_rv++;
            adv();
        end
        idle_inputs();
        sample();
        if (bus_rvalid_o) n_rv++;
        chk("alt_accesses", 32'(n_acc), 32'(8));
        chk("alt_rvalids", 32'(n_rv), 32'(4));
        w = cells[6];
        chk("alt_disp", 32'({disp_bg_o, disp_fg_o, disp_char_o}), 32'(w));
        adv();

        // Starved bus: counter saturates, then clear wins over increment.
        display_en_i = 1'b1; disp_active_i = 1'b1; bus_req_i = 1'b1; bus_we_i = 1'b0;
        any_gnt = 1'b0;
        for (int i = 0; i < 70000; i++) begin
            sample();
            if (bus_gnt_o) any_gnt = 1'b1;
            adv();
        end
        sample();
        chk("starve_no_gnt", 32'(any_gnt), 32'(1'b0));
        chk("stall_saturated", 32'(stall_cnt_o), 32'(16'hFFFF));
        stall_clr_i = 1'b1;
        adv();
        idle_inputs();
        sample();
        chk("stall_clr_priority", 32'(stall_cnt_o), 32'(16'h0000));
        adv();

        // Reset right after a read grant: response is dropped.
        bus_req_i = 1'b1; bus_we_i = 1'b0; bus_addr_i = 14'h0100;
        sample();
        chk("pre_reset_gnt", 32'(bus_gnt_o), 32'(1'b1));
        adv();
        rst_ni = 1'b0;
        sample();
        chk("in_reset_gnt", 32'(bus_gnt_o), 32'(1'b0));
        chk("in_reset_req", 32'(mem_req_o), 32'(1'b0));
        adv();
        rst_ni = 1'b1;
        idle_inputs();
        sample();
        chk("post_reset_rvalid", 32'(bus_rvalid_o), 32'(1'b0));
        chk("post_reset_disp", 32'({disp_bg_o, disp_fg_o, disp_char_o}), 32'(16'h0000));
        chk("post_reset_stall", 32'(stall_cnt_o), 32'(16'h0000));
        chk("post_reset_req", 32'(mem_req_o), 32'(1'b0));
        adv();
        sample();
        chk("post_reset_rvalid2", 32'(bus_rvalid_o), 32'(1'b0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
